// File: rtl/grid_pkg.sv
// Shared defaults and types for the grid row collector.
// Optional per-word parity is enabled by GRID_ROW_COLLECTOR_PARITY_EN.
package grid_pkg;

  localparam int ROWS_DEF  = 4;
  localparam int BEATS_DEF = 2;
  localparam int DEPTH_DEF = 4;
  localparam int WORD_DEF  = ROWS_DEF * BEATS_DEF;

  typedef logic [WORD_DEF-1:0] word_t;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int LVL_W = lvl_w(DEPTH_DEF);

endpackage

// File: rtl/grid_collect_fifo.sv
// Word FIFO for the grid row collector.
// Extra level bit separates full from empty; head data reads 0 when empty.
module grid_collect_fifo
  import grid_pkg::*;
#(
  parameter int W     = WORD_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = lvl_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic          do_pop;
  logic          do_push;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd    <= '0;
      wr    <= '0;
      level <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      level <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop)  rd <= rd + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr] <= din;
  end

endmodule

// File: rtl/grid_row_collector.sv
// Packs BEATS row samples into a word and queues it in a FIFO.
// GRID_ROW_COLLECTOR_PARITY_EN adds a stored word_parity output.
module grid_row_collector
  import grid_pkg::*;
#(
  parameter int ROWS   = ROWS_DEF,
  parameter int BEATS  = BEATS_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int WORD_W = ROWS * BEATS,
  localparam int LW     = lvl_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROWS-1:0]   row_in,
  input  logic              row_valid,
  input  logic              flush,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
`ifdef GRID_ROW_COLLECTOR_PARITY_EN
  output logic              word_parity,
`endif
  output logic [LW-1:0]     level,
  output logic              overflow
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
`ifdef GRID_ROW_COLLECTOR_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int FW = WORD_W + PW;

  logic [BW-1:0]     beat;
  logic [WORD_W-1:0] part;
  logic [WORD_W-1:0] asm;
  logic              last;
  logic              full;
  logic              empty;
  logic              pop;
  logic [FW-1:0]     fin;
  logic [FW-1:0]     fout;

  always_comb begin
    asm = part;
    asm[beat*ROWS +: ROWS] = row_in;
  end

  assign last       = row_valid && (beat == BW'(BEATS-1));
  assign word_valid = !empty;
  assign pop        = word_ready && word_valid;

`ifdef GRID_ROW_COLLECTOR_PARITY_EN
  assign fin         = {^asm, asm};
  assign word_parity = fout[WORD_W];
`else
  assign fin         = asm;
`endif
  assign word_data   = fout[WORD_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat     <= '0;
      part     <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      beat     <= '0;
      part     <= '0;
      overflow <= 1'b0;
    end else begin
      if (row_valid) begin
        if (last) begin
          beat <= '0;
          part <= '0;
        end else begin
          beat <= beat + 1'b1;
          part <= asm;
        end
      end
      // a completed word with nowhere to go is dropped
      if (last && full && !pop) overflow <= 1'b1;
    end
  end

  grid_collect_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (last),
    .din   (fin),
    .pop   (word_ready),
    .dout  (fout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule
